// File: rtl/ram_ctrl_pkg.sv
// Shared constants for the RAM command port: opcodes, arbiter FSM states
// and requester ids.
package ram_ctrl_pkg;

  // 2-bit opcode carried in the top bits of ram_din
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Requester ids, also used as the arbiter grant index
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_CMD  = 3'd4,
    ST_RD_WAIT = 3'd5
  } state_e;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. The grant is combinational; the
// last-grant register only moves when the caller actually accepts.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last_grant_q;
  logic last_grant_d;

  // Lone requester wins; a tie goes to the port that was not served last
  always_comb begin
    gnt_id       = PORT_A;
    gnt          = 2'b00;
    last_grant_d = last_grant_q;
    if (req == 2'b11) begin
      gnt_id = ~last_grant_q;
    end else if (req[1]) begin
      gnt_id = PORT_B;
    end
    if (req != 2'b00) begin
      gnt = (gnt_id == PORT_B) ? 2'b10 : 2'b01;
      if (update_en) begin
        last_grant_d = gnt_id;
      end
    end
  end

  // Last-grant register; B after reset so A wins the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= PORT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the command-driven single-port RAM between requester A (SPI side)
// and requester B (local host). Each accepted transaction is expanded into
// the RAM's opcode sequence; read data is routed back to the owning port.
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_W     = 8,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_req_valid,
  input  logic                 a_req_we,
  input  logic [ADDR_SIZE-1:0] a_req_addr,
  input  logic [DATA_W-1:0]    a_req_wdata,
  output logic                 a_req_ready,
  output logic                 a_rsp_valid,
  output logic                 a_rsp_err,
  output logic [DATA_W-1:0]    a_rsp_rdata,
  input  logic                 b_req_valid,
  input  logic                 b_req_we,
  input  logic [ADDR_SIZE-1:0] b_req_addr,
  input  logic [DATA_W-1:0]    b_req_wdata,
  output logic                 b_req_ready,
  output logic                 b_rsp_valid,
  output logic                 b_rsp_err,
  output logic [DATA_W-1:0]    b_rsp_rdata,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [DATA_W-1:0]    ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 busy
);

  localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic                   owner_q, owner_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   a_rsp_valid_q, a_rsp_valid_d, a_rsp_err_q, a_rsp_err_d;
  logic                   b_rsp_valid_q, b_rsp_valid_d, b_rsp_err_q, b_rsp_err_d;
  logic [DATA_W-1:0]      a_rsp_rdata_q, a_rsp_rdata_d, b_rsp_rdata_q, b_rsp_rdata_d;

  logic [1:0]             arb_req;
  logic [1:0]             arb_gnt;
  logic                   arb_id;
  logic                   accept;

  // Arbitration only happens in IDLE, and never while reset is held
  assign arb_req = {b_req_valid, a_req_valid};
  assign accept  = rst_n && (state_q == ST_IDLE) && (arb_req != 2'b00);

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (arb_req),
    .update_en (accept),
    .gnt       (arb_gnt),
    .gnt_id    (arb_id)
  );

  assign a_req_ready = accept && arb_gnt[0];
  assign b_req_ready = accept && arb_gnt[1];
  assign busy        = (state_q != ST_IDLE);
  assign a_rsp_valid = a_rsp_valid_q;
  assign a_rsp_err   = a_rsp_err_q;
  assign a_rsp_rdata = a_rsp_rdata_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign b_rsp_err   = b_rsp_err_q;
  assign b_rsp_rdata = b_rsp_rdata_q;

  // Next-state, transaction latch, RAM command decode and response update
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    a_rsp_valid_d = 1'b0;
    a_rsp_err_d   = 1'b0;
    b_rsp_valid_d = 1'b0;
    b_rsp_err_d   = 1'b0;
    a_rsp_rdata_d = a_rsp_rdata_q;
    b_rsp_rdata_d = b_rsp_rdata_q;
    ram_din       = '0;
    ram_rx_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = arb_id;
          we_d    = (arb_id == PORT_B) ? b_req_we    : a_req_we;
          addr_d  = (arb_id == PORT_B) ? b_req_addr  : a_req_addr;
          wdata_d = (arb_id == PORT_B) ? b_req_wdata : a_req_wdata;
          state_d = we_d ? ST_WR_ADDR : ST_RD_ADDR;
        end
      end
      ST_WR_ADDR: begin
        ram_din      = {CMD_WR_ADDR, addr_q};
        ram_rx_valid = 1'b1;
        state_d      = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        ram_din      = {CMD_WR_DATA, wdata_q};
        ram_rx_valid = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_RD_ADDR: begin
        ram_din      = {CMD_RD_ADDR, addr_q};
        ram_rx_valid = 1'b1;
        state_d      = ST_RD_CMD;
      end
      ST_RD_CMD: begin
        ram_din      = {CMD_RD_DATA, {ADDR_SIZE{1'b0}}};
        ram_rx_valid = 1'b1;
        cnt_d        = '0;
        state_d      = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (ram_tx_valid) begin
          if (owner_q == PORT_B) begin
            b_rsp_valid_d = 1'b1;
            b_rsp_rdata_d = ram_dout;
          end else begin
            a_rsp_valid_d = 1'b1;
            a_rsp_rdata_d = ram_dout;
          end
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
          if (owner_q == PORT_B) begin
            b_rsp_valid_d = 1'b1;
            b_rsp_err_d   = 1'b1;
          end else begin
            a_rsp_valid_d = 1'b1;
            a_rsp_err_d   = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Hold the RAM idle while reset is asserted so an aborted write never
    // reaches the data phase
    if (!rst_n) begin
      ram_din      = '0;
      ram_rx_valid = 1'b0;
    end
  end

  // State, transaction and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      we_q          <= 1'b0;
      owner_q       <= PORT_A;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      a_rsp_valid_q <= 1'b0;
      a_rsp_err_q   <= 1'b0;
      a_rsp_rdata_q <= '0;
      b_rsp_valid_q <= 1'b0;
      b_rsp_err_q   <= 1'b0;
      b_rsp_rdata_q <= '0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      owner_q       <= owner_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      a_rsp_err_q   <= a_rsp_err_d;
      a_rsp_rdata_q <= a_rsp_rdata_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      b_rsp_err_q   <= b_rsp_err_d;
      b_rsp_rdata_q <= b_rsp_rdata_d;
    end
  end

endmodule
